// File: rtl/sdp_core_unpack_if.sv
// rtl/sdp_core_unpack_if.sv - beat input / word output handshake bundle for sdp_core_unpack
interface sdp_core_unpack_if #(
    parameter int IW = 128,
    parameter int OW = 512
);
    logic          inp_pvld;
    logic          inp_prdy;
    logic [IW-1:0] inp_data;
    logic          inp_flush;
    logic          out_pvld;
    logic          out_prdy;
    logic [OW-1:0] out_data;

    modport master (
        output inp_pvld, inp_data, inp_flush, out_prdy,
        input  inp_prdy, out_pvld, out_data
    );

    modport slave (
        input  inp_pvld, inp_data, inp_flush, out_prdy,
        output inp_prdy, out_pvld, out_data
    );
endinterface

// File: rtl/sdp_core_unpack.sv
// rtl/sdp_core_unpack.sv - packs RATIO IW-bit beats into one OW-bit word, flush ends a word early
// Optional SDP_CORE_UNPACK_SKID_EN: 2-entry output FIFO instead of a single output register.
module sdp_core_unpack #(
    parameter int IW    = 128,
    parameter int OW    = 512,
    parameter int RATIO = OW / IW
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    sdp_core_unpack_if.slave bus
);
    if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8 || RATIO == 16)) begin : g_bad_ratio
        $error("sdp_core_unpack: RATIO must be 1, 2, 4, 8 or 16");
    end

    localparam logic [3:0] LAST = 4'(RATIO - 1);

    logic [3:0]    cnt;
    logic          final_beat;
    logic          space;
    logic          inp_acc;
    logic          out_acc;
    logic          push;
    logic [OW-1:0] word;

    // a flush on the last slot is just a normal complete word, so OR-ing it in is harmless
    assign final_beat   = (cnt == LAST) || bus.inp_flush;
    assign bus.inp_prdy = !final_beat || space;
    assign inp_acc      = bus.inp_pvld && bus.inp_prdy;
    assign out_acc      = bus.out_pvld && bus.out_prdy;
    assign push         = inp_acc && final_beat;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt <= 4'd0;
        end else if (inp_acc) begin
            cnt <= final_beat ? 4'd0 : cnt + 4'd1;
        end
    end

    if (RATIO == 1) begin : g_bypass
        assign word = bus.inp_data;
    end else begin : g_acc
        logic [(RATIO-1)*IW-1:0] acc;

        always_ff @(posedge nvdla_core_clk) begin
            if (inp_acc && !final_beat) begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (cnt == 4'(k)) begin
                        acc[k*IW +: IW] <= bus.inp_data;
                    end
                end
            end
        end

        // segments above the final beat are forced to zero so stale beats never leak out
        always_comb begin
            word = '0;
            for (int k = 0; k < RATIO - 1; k++) begin
                if (4'(k) < cnt) begin
                    word[k*IW +: IW] = acc[k*IW +: IW];
                end
            end
            for (int k = 0; k < RATIO; k++) begin
                if (4'(k) == cnt) begin
                    word[k*IW +: IW] = bus.inp_data;
                end
            end
        end
    end

`ifdef SDP_CORE_UNPACK_SKID_EN
    logic [OW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;

    // space comes from registered occupancy only, breaking the out_prdy -> inp_prdy path
    assign space        = (occ != 2'd2);
    assign bus.out_pvld = (occ != 2'd0);
    assign bus.out_data = mem[rd_ptr];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (out_acc) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, out_acc})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end
`else
    logic [OW-1:0] out_reg;
    logic          out_vld;

    assign space        = !out_vld || bus.out_prdy;
    assign bus.out_pvld = out_vld;
    assign bus.out_data = out_reg;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_vld <= 1'b0;
        end else if (push) begin
            out_vld <= 1'b1;
        end else if (out_acc) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            out_reg <= word;
        end
    end
`endif
endmodule

// File: tb/tb_sdp_core_unpack.sv
// tb/tb_sdp_core_unpack.sv - directed self-checking bench for sdp_core_unpack (RATIO 4 and RATIO 1)
module tb_sdp_core_unpack;
    localparam int IW = 128;
    localparam int OW = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   nacc = 0;
    int   acc_cyc = 0;
    bit   sdone = 1'b0;

    logic [OW-1:0] wq [$];
    int            wc [$];

    sdp_core_unpack_if #(.IW(IW), .OW(OW)) bus ();
    sdp_core_unpack_if #(.IW(OW), .OW(OW)) bus1 ();

    sdp_core_unpack #(.IW(IW), .OW(OW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .bus            (bus.slave)
    );

    sdp_core_unpack #(.IW(OW), .OW(OW)) dut1 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .bus            (bus1.slave)
    );

    always #5 clk = !clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.out_pvld && bus.out_prdy) begin
            wq.push_back(bus.out_data);
            wc.push_back(cyc);
        end
    end

    function automatic logic [OW-1:0] mk4(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                          input logic [IW-1:0] c, input logic [IW-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input bit f, input bit exp_final);
        bit ok = 1'b0;
        bus.inp_pvld  = 1'b1;
        bus.inp_data  = d;
        bus.inp_flush = f;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.inp_prdy) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                nacc    = nacc + 1;
            end else begin
                vectors++;
                if (!exp_final) begin
                    miscompares++;
                    $display("FAIL prdy_nonfinal: inp_prdy=0 on non-final beat %0h, required 1", d);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.inp_pvld  = 1'b0;
        bus.inp_flush = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_timeout: beat %0h not accepted, required acceptance", d);
        end
    endtask

    task automatic wait_words(input int n);
        int i = 0;
        while (wq.size() < n && i < 100) begin
            @(negedge clk);
            i++;
        end
        vectors++;
        if (wq.size() < n) begin
            miscompares++;
            $display("FAIL word_timeout: got %0d words, required %0d", wq.size(), n);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.out_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_pvld: got %b, required 0", bus.out_pvld);
        end
        vectors++;
        if (bus.inp_prdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_inp_prdy: got %b, required 1", bus.inp_prdy);
        end
        vectors++;
        if (bus1.out_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_pvld_r1: got %b, required 0", bus1.out_pvld);
        end
        align();
        rst_n = 1'b1;
        align();
    endtask

    task automatic test_basic();
        int c4;
        bus.out_prdy = 1'b1;
        wq.delete();
        wc.delete();
        send(128'h1, 1'b0, 1'b0);
        send(128'h2, 1'b0, 1'b0);
        send(128'h3, 1'b0, 1'b0);
        send(128'h4, 1'b0, 1'b1);
        c4 = acc_cyc;
        wait_words(1);
        if (wq.size() >= 1) begin
            vectors++;
            if (wq[0] !== mk4(128'h1, 128'h2, 128'h3, 128'h4)) begin
                miscompares++;
                $display("FAIL basic_word: got %h, required {4,3,2,1}", wq[0]);
            end
            vectors++;
            if (wc[0] != c4 + 1) begin
                miscompares++;
                $display("FAIL basic_latency: out_pvld at cycle %0d, required %0d", wc[0], c4 + 1);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.out_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drop: out_pvld=%b after accept, required 0", bus.out_pvld);
        end
        align();
    endtask

    task automatic test_flush();
        bus.out_prdy = 1'b1;
        wq.delete();
        wc.delete();
        send(128'hA, 1'b0, 1'b0);
        send(128'hB, 1'b1, 1'b1);
        send(128'hC, 1'b0, 1'b0);
        send(128'hD, 1'b0, 1'b0);
        send(128'hE, 1'b0, 1'b0);
        send(128'hF, 1'b1, 1'b1);
        send(128'h11, 1'b1, 1'b1);
        wait_words(3);
        if (wq.size() >= 3) begin
            vectors++;
            if (wq[0] !== mk4(128'hA, 128'hB, 128'h0, 128'h0)) begin
                miscompares++;
                $display("FAIL flush_word: got %h, required {0,0,B,A}", wq[0]);
            end
            vectors++;
            if (wq[1] !== mk4(128'hC, 128'hD, 128'hE, 128'hF)) begin
                miscompares++;
                $display("FAIL flush_cnt_restart: got %h, required {F,E,D,C}", wq[1]);
            end
            vectors++;
            if (wq[2] !== mk4(128'h11, 128'h0, 128'h0, 128'h0)) begin
                miscompares++;
                $display("FAIL flush_cnt0: got %h, required {0,0,0,11}", wq[2]);
            end
        end
        align();
    endtask

    task automatic test_stall();
        int exp_acc;
        int i;
`ifdef SDP_CORE_UNPACK_SKID_EN
        exp_acc = 11;
`else
        exp_acc = 7;
`endif
        bus.out_prdy = 1'b0;
        wq.delete();
        wc.delete();
        nacc  = 0;
        sdone = 1'b0;
        fork
            begin
                for (int b = 0; b < 12; b++) begin
                    send(IW'(32'h21 + b), 1'b0, (b % 4) == 3);
                end
                sdone = 1'b1;
            end
        join_none
        repeat (30) @(negedge clk);
        vectors++;
        if (nacc != exp_acc) begin
            miscompares++;
            $display("FAIL stall_accepted: got %0d beats, required %0d", nacc, exp_acc);
        end
        vectors++;
        if (bus.out_pvld !== 1'b1 || bus.out_data !== mk4(128'h21, 128'h22, 128'h23, 128'h24)) begin
            miscompares++;
            $display("FAIL stall_hold: pvld=%b data=%h, required 1 and {24,23,22,21}",
                     bus.out_pvld, bus.out_data);
        end
        align();
        bus.out_prdy = 1'b1;
        i = 0;
        while (!sdone && i < 200) begin
            @(negedge clk);
            i++;
        end
        wait_words(3);
        if (wq.size() >= 3) begin
            vectors++;
            if (wq[0] !== mk4(128'h21, 128'h22, 128'h23, 128'h24) ||
                wq[1] !== mk4(128'h25, 128'h26, 128'h27, 128'h28) ||
                wq[2] !== mk4(128'h29, 128'h2A, 128'h2B, 128'h2C)) begin
                miscompares++;
                $display("FAIL stall_order: got %h / %h / %h, required words 21..2C in order",
                         wq[0][127:0], wq[1][127:0], wq[2][127:0]);
            end
            vectors++;
            if (wc[1] != wc[0] + 1) begin
                miscompares++;
                $display("FAIL stall_no_bubble: word2 at %0d, required %0d", wc[1], wc[0] + 1);
            end
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (wq.size() != 3) begin
            miscompares++;
            $display("FAIL stall_count: got %0d words, required 3", wq.size());
        end
        align();
    endtask

    task automatic test_back_to_back();
        bus.out_prdy = 1'b1;
        wq.delete();
        wc.delete();
        for (int b = 0; b < 12; b++) begin
            send(IW'(32'h41 + b), 1'b0, (b % 4) == 3);
        end
        wait_words(3);
        if (wq.size() >= 3) begin
            vectors++;
            if (wq[2] !== mk4(128'h49, 128'h4A, 128'h4B, 128'h4C)) begin
                miscompares++;
                $display("FAIL b2b_word3: got %h, required {4C,4B,4A,49}", wq[2]);
            end
            vectors++;
            if (wc[1] != wc[0] + 4 || wc[2] != wc[1] + 4) begin
                miscompares++;
                $display("FAIL b2b_rate: words at %0d %0d %0d, required spacing 4",
                         wc[0], wc[1], wc[2]);
            end
        end
        align();
    endtask

    task automatic test_reset_mid();
        bus.out_prdy = 1'b0;
        send(128'h51, 1'b0, 1'b0);
        send(128'h52, 1'b0, 1'b0);
        send(128'h53, 1'b0, 1'b0);
        send(128'h54, 1'b0, 1'b1);
        send(128'h31, 1'b0, 1'b0);
        send(128'h32, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: out_pvld=%b, required 0", bus.out_pvld);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.out_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: out_pvld=%b, required 0", bus.out_pvld);
        end
        wq.delete();
        wc.delete();
        align();
        rst_n = 1'b1;
        bus.out_prdy = 1'b1;
        align();
        send(128'h5, 1'b0, 1'b0);
        send(128'h6, 1'b0, 1'b0);
        send(128'h7, 1'b0, 1'b0);
        send(128'h8, 1'b0, 1'b1);
        wait_words(1);
        repeat (3) @(negedge clk);
        vectors++;
        if (wq.size() != 1 || wq[0] !== mk4(128'h5, 128'h6, 128'h7, 128'h8)) begin
            miscompares++;
            $display("FAIL reset_first_word: %0d words, first %h, required one {8,7,6,5}",
                     wq.size(), wq.size() > 0 ? wq[0] : '0);
        end
        align();
    endtask

    task automatic test_ratio1();
        logic [OW-1:0] exp;
        bus1.out_prdy = 1'b1;
        for (int t = 0; t < 2; t++) begin
            exp            = (t == 0) ? OW'(32'hFF) : OW'(32'hAB);
            bus1.inp_pvld  = 1'b1;
            bus1.inp_data  = exp;
            bus1.inp_flush = (t == 0);
            @(negedge clk);
            vectors++;
            if (bus1.inp_prdy !== 1'b1) begin
                miscompares++;
                $display("FAIL r1_prdy: got %b, required 1", bus1.inp_prdy);
            end
            align();
            bus1.inp_pvld  = 1'b0;
            bus1.inp_flush = 1'b0;
            @(negedge clk);
            vectors++;
            if (bus1.out_pvld !== 1'b1 || bus1.out_data !== exp) begin
                miscompares++;
                $display("FAIL r1_word: pvld=%b data=%h, required 1 and %h",
                         bus1.out_pvld, bus1.out_data[31:0], exp[31:0]);
            end
            align();
        end
        @(negedge clk);
        vectors++;
        if (bus1.out_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL r1_drop: out_pvld=%b, required 0", bus1.out_pvld);
        end
        align();
    endtask

    initial begin
        bus.inp_pvld   = 1'b0;
        bus.inp_data   = '0;
        bus.inp_flush  = 1'b0;
        bus.out_prdy   = 1'b0;
        bus1.inp_pvld  = 1'b0;
        bus1.inp_data  = '0;
        bus1.inp_flush = 1'b0;
        bus1.out_prdy  = 1'b0;
        test_reset();
        test_basic();
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_ratio1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
